// File: rtl/branch_resolver_pkg.sv
// Shared constants for the fetch/execute PC-correction path.
// Holds the PC width and the resolver FSM encodings.
package branch_resolver_pkg;

    localparam int unsigned WORD_SIZE = 16;

    typedef enum logic {
        BR_NORMAL  = 1'b0,
        BR_RECOVER = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Prediction push, EX resolution and correction/statistics signals between the
// pipeline (master) and the branch resolver (slave).
interface branch_resolver_if #(
    parameter int unsigned WORD_SIZE = branch_resolver_pkg::WORD_SIZE,
    parameter int unsigned CNT_W     = 16
);

    logic                 push_valid;
    logic [WORD_SIZE-1:0] push_pc;
    logic [WORD_SIZE-1:0] push_pred;
    logic                 push_ready;
    logic                 ex_valid;
    logic [WORD_SIZE-1:0] ex_pc;
    logic [WORD_SIZE-1:0] ex_next;
    logic                 force_pc;
    logic [WORD_SIZE-1:0] force_pc_data;
    logic [WORD_SIZE-1:0] ex_pc_out;
    logic [CNT_W-1:0]     mispredict_count;
    logic [CNT_W-1:0]     resolve_count;
    logic                 underflow;

    modport master (
        output push_valid, push_pc, push_pred, ex_valid, ex_pc, ex_next,
        input  push_ready, force_pc, force_pc_data, ex_pc_out,
               mispredict_count, resolve_count, underflow
    );

    modport slave (
        input  push_valid, push_pc, push_pred, ex_valid, ex_pc, ex_next,
        output push_ready, force_pc, force_pc_data, ex_pc_out,
               mispredict_count, resolve_count, underflow
    );

endinterface

// File: rtl/branch_resolver_pred_fifo.sv
// In-order queue of {fetched pc, predicted next pc} with push, pop and a
// whole-queue clear that overrides both.
module branch_resolver_pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter  int unsigned DATA_W   = WORD_SIZE,
    parameter  int unsigned DEPTH    = 4,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_push,
    input  logic [DATA_W-1:0]   i_pc,
    input  logic [DATA_W-1:0]   i_pred,
    input  logic                i_pop,
    input  logic                i_clear,
    output logic [DATA_W-1:0]   o_head_pc,
    output logic [DATA_W-1:0]   o_head_pred,
    output logic [CNT_BITS-1:0] o_count,
    output logic                o_full,
    output logic                o_empty
);

    logic [DATA_W-1:0]   r_mem_pc   [DEPTH];
    logic [DATA_W-1:0]   r_mem_pred [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic                w_do_push;
    logic                w_do_pop;

    always_comb begin
        o_full      = (r_count == CNT_BITS'(DEPTH));
        o_empty     = (r_count == '0);
        w_do_pop    = i_pop && !o_empty;
        // A push into a full queue is legal only when the head leaves in the same cycle.
        w_do_push   = i_push && (!o_full || w_do_pop);
        o_count     = r_count;
        o_head_pc   = r_mem_pc[r_rd_ptr];
        o_head_pred = r_mem_pred[r_rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_BITS'(1);
                2'b01:   r_count <= r_count - CNT_BITS'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem_pc[r_wr_ptr]   <= i_pc;
            r_mem_pred[r_wr_ptr] <= i_pred;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage resolver: checks each buffered fetch prediction against the resolved
// next PC, pulses a registered correction on mismatch and keeps saturating statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned WORD_SIZE = branch_resolver_pkg::WORD_SIZE,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic            clk,
    input  logic            reset,
    branch_resolver_if.slave bus
);

    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    br_state_e            r_state;
    br_state_e            w_state_next;
    logic                 w_pop_now;
    logic                 w_mismatch;
    logic                 w_push;
    logic                 w_push_ready;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_BITS-1:0]  w_count;
    logic [WORD_SIZE-1:0] w_head_pc;
    logic [WORD_SIZE-1:0] w_head_pred;

    logic                 r_force_pc;
    logic [WORD_SIZE-1:0] r_force_pc_data;
    logic [WORD_SIZE-1:0] r_ex_pc_out;
    logic [CNT_W-1:0]     r_mispredict_count;
    logic [CNT_W-1:0]     r_resolve_count;
    logic                 r_underflow;

    branch_resolver_pred_fifo #(
        .DATA_W (WORD_SIZE),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pc        (bus.push_pc),
        .i_pred      (bus.push_pred),
        .i_pop       (w_pop_now),
        .i_clear     (w_mismatch),
        .o_head_pc   (w_head_pc),
        .o_head_pred (w_head_pred),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_pop_now    = (r_state == BR_NORMAL) && bus.ex_valid && !w_empty;
        w_mismatch   = w_pop_now &&
                       ((w_head_pred != bus.ex_next) || (w_head_pc != bus.ex_pc));
        w_push_ready = (r_state == BR_NORMAL) && (!w_full || w_pop_now);
        // The flush on a mismatch also drops whatever IF offers in that cycle.
        w_push       = bus.push_valid && w_push_ready && !w_mismatch;
        w_state_next = r_state;
        case (r_state)
            BR_NORMAL:  if (w_mismatch) w_state_next = BR_RECOVER;
            BR_RECOVER: w_state_next = BR_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BR_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_force_pc         <= 1'b0;
            r_force_pc_data    <= '0;
            r_ex_pc_out        <= '0;
            r_mispredict_count <= '0;
            r_resolve_count    <= '0;
            r_underflow        <= 1'b0;
        end else begin
            r_force_pc <= w_mismatch;
            if (w_mismatch) begin
                r_force_pc_data <= bus.ex_next;
                r_ex_pc_out     <= bus.ex_pc;
            end
            if (w_pop_now && (r_resolve_count != '1)) begin
                r_resolve_count <= r_resolve_count + CNT_W'(1);
            end
            if (w_mismatch && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
            if ((r_state == BR_NORMAL) && bus.ex_valid && (w_count == '0)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.push_ready       = w_push_ready;
    assign bus.force_pc         = r_force_pc;
    assign bus.force_pc_data    = r_force_pc_data;
    assign bus.ex_pc_out        = r_ex_pc_out;
    assign bus.mispredict_count = r_mispredict_count;
    assign bus.resolve_count    = r_resolve_count;
    assign bus.underflow        = r_underflow;

endmodule
